box_bounce_gen: RTL

Pixel source that sits directly upstream of the VGA timing/display stage. It drives the 12-bit RGB input from the display's pixel coordinates and v_sync. The block draws a solid square that moves a fixed step each frame inside a rectangular play area, bounces off the walls, and changes colour on each bounce. Motion updates only during vertical blanking, so there is no tearing. The pixel path is registered with one-pixel lookahead, so its output lines up with the display's combinational RGB sampling.

---
 rtl/box_bounce_pkg.sv | 21 ++
 rtl/box_bounce_gen_axis.sv | 52 +++++
 rtl/box_bounce_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/box_bounce_pkg.sv
// box_bounce_pkg
// Shared definitions for the bouncing-box pixel source: FSM state encoding,
// the 8-entry colour palette stepped on every bounce frame, and the colour
// used for the optional play-area outline.
package box_bounce_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_MOVE_X = 2'd1,
        S_MOVE_Y = 2'd2,
        S_COLOR  = 2'd3
    } state_t;

    localparam logic [11:0] PALETTE [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'h0FF, 12'hF0F, 12'hF80, 12'hFFF
    };

    localparam logic [11:0] BORDER_RGB = 12'hFFF;

endpackage

// File: rtl/box_bounce_gen_axis.sv
// box_axis_step
// Combinational one-axis motion step with wall clamping.
//   pos      in   10  current top-left coordinate on this axis
//   dir      in    1  1 = increasing coordinate, 0 = decreasing
//   lo       in   10  lowest legal coordinate
//   hi       in   10  highest legal coordinate
//   step     in   10  displacement per frame
//   pos_nxt  out  10  coordinate after this frame's step
//   dir_nxt  out   1  direction after this frame's step
//   hit      out   1  this step touched a wall (position clamped, dir flipped)
// Sums and differences are done in 11 bits so nothing wraps near the limits.
module box_axis_step (
    input  logic [9:0] pos,
    input  logic       dir,
    input  logic [9:0] lo,
    input  logic [9:0] hi,
    input  logic [9:0] step,
    output logic [9:0] pos_nxt,
    output logic       dir_nxt,
    output logic       hit
);

    logic [10:0] pos_plus;
    logic [10:0] lo_plus;

    assign pos_plus = {1'b0, pos} + {1'b0, step};
    assign lo_plus  = {1'b0, lo} + {1'b0, step};

    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        hit     = 1'b0;
        if (dir) begin
            if (pos_plus > {1'b0, hi}) begin
                pos_nxt = hi;
                dir_nxt = 1'b0;
                hit     = 1'b1;
            end else begin
                pos_nxt = pos_plus[9:0];
            end
        end else begin
            if ({1'b0, pos} < lo_plus) begin
                pos_nxt = lo;
                dir_nxt = 1'b1;
                hit     = 1'b1;
            end else begin
                pos_nxt = pos - step;
            end
        end
    end

endmodule

// File: rtl/box_bounce_gen.sv
// box_bounce_gen
// Pixel source drawing a solid square that moves one step per frame inside
// a rectangular play area, bouncing off its walls and changing colour on
// every frame that contains a bounce. Motion is applied only during vertical
// blanking; the pixel path looks one pixel ahead so the registered colour
// lines up with the display's current h_pos.
//   clk_25MHz   in   1   pixel clock
//   rst_        in   1   asynchronous active-low reset
//   h_pos       in  10   display horizontal position
//   v_pos       in  10   display vertical position
//   v_sync      in   1   display vertical sync, active-low
//   pause       in   1   freeze motion, sampled at the frame tick
//   rgb_out     out 12   {r,g,b} pixel colour
//   bounce_cnt  out  8   frames containing at least one bounce, saturating
// Build option: define BOX_BOUNCE_BORDER_EN to draw the play-area outline.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_WAIT   | idle, waiting for an unpaused frame tick
// S_MOVE_X | apply horizontal step, record a wall hit
// S_MOVE_Y | apply vertical step, record a wall hit
// S_COLOR  | on a bounce frame advance colour and count; clear bounce flag
module box_bounce_gen
    import box_bounce_pkg::*;
#(
    parameter int          BOX_SIZE = 32,
    parameter int          STEP     = 2,
    parameter int          AREA_X0  = 100,
    parameter int          AREA_X1  = 540,
    parameter int          AREA_Y0  = 40,
    parameter int          AREA_Y1  = 440,
    parameter logic [11:0] BG_RGB   = 12'h000
) (
    input  logic        clk_25MHz,
    input  logic        rst_,
    input  logic [9:0]  h_pos,
    input  logic [9:0]  v_pos,
    input  logic        v_sync,
    input  logic        pause,
    output logic [11:0] rgb_out,
    output logic [7:0]  bounce_cnt
);

    localparam logic [9:0]  X_MIN  = 10'(AREA_X0 + 1);
    localparam logic [9:0]  X_MAX  = 10'(AREA_X1 - BOX_SIZE);
    localparam logic [9:0]  Y_MIN  = 10'(AREA_Y0 + 1);
    localparam logic [9:0]  Y_MAX  = 10'(AREA_Y1 - BOX_SIZE);
    localparam logic [9:0]  STEP_V = 10'(STEP);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

    state_t      state, state_nxt;
    logic        vs_q;
    logic        tick;
    logic [9:0]  x, y;
    logic        dir_x, dir_y;
    logic [2:0]  col_idx;
    logic        bnc;
    logic        ld_x, ld_y, ld_col;

    logic [9:0]  x_nxt, y_nxt;
    logic        dir_x_nxt, dir_y_nxt;
    logic        hit_x, hit_y;

    // Rising edge of the active-low sync pulse: once per frame, in blanking.
    assign tick = v_sync & ~vs_q;

    always_ff @(posedge clk_25MHz or negedge rst_) begin
        if (!rst_) vs_q <= 1'b1;
        else       vs_q <= v_sync;
    end

    box_axis_step u_step_x (
        .pos     (x),
        .dir     (dir_x),
        .lo      (X_MIN),
        .hi      (X_MAX),
        .step    (STEP_V),
        .pos_nxt (x_nxt),
        .dir_nxt (dir_x_nxt),
        .hit     (hit_x)
    );

    box_axis_step u_step_y (
        .pos     (y),
        .dir     (dir_y),
        .lo      (Y_MIN),
        .hi      (Y_MAX),
        .step    (STEP_V),
        .pos_nxt (y_nxt),
        .dir_nxt (dir_y_nxt),
        .hit     (hit_y)
    );

    always_ff @(posedge clk_25MHz or negedge rst_) begin
        if (!rst_) state <= S_WAIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_x      = 1'b0;
        ld_y      = 1'b0;
        ld_col    = 1'b0;
        case (state)
            S_WAIT: begin
                if (tick && !pause) state_nxt = S_MOVE_X;
            end
            S_MOVE_X: begin
                ld_x      = 1'b1;
                state_nxt = S_MOVE_Y;
            end
            S_MOVE_Y: begin
                ld_y      = 1'b1;
                state_nxt = S_COLOR;
            end
            S_COLOR: begin
                ld_col    = 1'b1;
                state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    // bnc collects hits from both axes so a corner hit counts as one bounce.
    always_ff @(posedge clk_25MHz or negedge rst_) begin
        if (!rst_) begin
            x          <= X_MIN;
            y          <= Y_MIN;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            col_idx    <= 3'd0;
            bnc        <= 1'b0;
            bounce_cnt <= 8'd0;
        end else begin
            if (ld_x) begin
                x     <= x_nxt;
                dir_x <= dir_x_nxt;
                if (hit_x) bnc <= 1'b1;
            end
            if (ld_y) begin
                y     <= y_nxt;
                dir_y <= dir_y_nxt;
                if (hit_y) bnc <= 1'b1;
            end
            if (ld_col) begin
                if (bnc) begin
                    col_idx <= col_idx + 3'd1;
                    if (bounce_cnt != 8'hFF) bounce_cnt <= bounce_cnt + 8'd1;
                end
                bnc <= 1'b0;
            end
        end
    end

    // One-pixel lookahead: colour computed for h_pos+1 and registered.
    logic [9:0]  nh;
    logic [10:0] nh_w, v_w, x_w, y_w;
    logic        in_box;
    logic [11:0] rgb_nxt;

    assign nh   = h_pos + 10'd1;
    assign nh_w = {1'b0, nh};
    assign v_w  = {1'b0, v_pos};
    assign x_w  = {1'b0, x};
    assign y_w  = {1'b0, y};

    assign in_box = (nh_w >= x_w) && (nh_w < x_w + BOX_W) &&
                    (v_w >= y_w) && (v_w < y_w + BOX_W);

`ifdef BOX_BOUNCE_BORDER_EN
    logic on_border;

    assign on_border =
        (((nh_w == 11'(AREA_X0)) || (nh_w == 11'(AREA_X1))) &&
         (v_w >= 11'(AREA_Y0)) && (v_w <= 11'(AREA_Y1))) ||
        (((v_w == 11'(AREA_Y0)) || (v_w == 11'(AREA_Y1))) &&
         (nh_w >= 11'(AREA_X0)) && (nh_w <= 11'(AREA_X1)));

    always_comb begin
        rgb_nxt = BG_RGB;
        if (in_box)         rgb_nxt = PALETTE[col_idx];
        else if (on_border) rgb_nxt = BORDER_RGB;
    end
`else
    always_comb begin
        rgb_nxt = BG_RGB;
        if (in_box) rgb_nxt = PALETTE[col_idx];
    end
`endif

    always_ff @(posedge clk_25MHz or negedge rst_) begin
        if (!rst_) rgb_out <= 12'h000;
        else       rgb_out <= rgb_nxt;
    end

endmodule
